// File: rtl/gpio_pkg.sv
// Shared GPIO constants: bank defaults and the direction encoding used by
// both the input-side filter and the output-side stage.
package gpio_pkg;

    localparam int unsigned GPIO_BANK_WIDTH  = 8;
    localparam int unsigned GPIO_SYNC_STAGES = 2;
    localparam int unsigned GPIO_FILT_CNT_W  = 4;

    localparam logic GPIO_DIR_IN  = 1'b1;
    localparam logic GPIO_DIR_OUT = 1'b0;

endpackage

// File: rtl/gpio_in_filter_bit.sv
// Single-bit input conditioning: synchronizer chain, glitch-filter counter,
// filtered level register and registered rise/fall pulses.
// SyncStages must be in the range 2..4.
module gpio_in_filter_bit
    import gpio_pkg::*;
#(
    parameter int unsigned SyncStages = GPIO_SYNC_STAGES,
    parameter int unsigned FiltCntW   = GPIO_FILT_CNT_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [FiltCntW-1:0] filt_len_i,
    input  logic                pad_i,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  s;
    logic [FiltCntW-1:0]   cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;

    assign s = sync_q[SyncStages-1];

    // Synchronizer shifts every cycle, independent of enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], pad_i};
        end
    end

    // Filter next state: a difference must persist past filt_len_i cycles.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!en_i) begin
            // Forced quiet; dropping the level here is not an edge.
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= filt_len_i) begin
            // >= also covers filt_len_i lowered below an in-flight count.
            cnt_d   = '0;
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Filter state and edge-pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/gpio_in_filter.sv
// Bank-level GPIO input filter: one gpio_in_filter_bit per I/O, gated by
// CONFIG_DONE and per-bit direction.
// Optional sticky edge-status register: define GPIO_IN_FILTER_STICKY_EN.
module gpio_in_filter
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = GPIO_BANK_WIDTH,
    parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int unsigned FILT_CNT_W  = GPIO_FILT_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CONFIG_DONE,
    input  logic [WIDTH-1:0]      DIR,
    input  logic [FILT_CNT_W-1:0] FILT_LEN,
    input  logic [WIDTH-1:0]      SOC_IN,
    output logic [WIDTH-1:0]      FPGA_IN,
    output logic [WIDTH-1:0]      RISE,
`ifdef GPIO_IN_FILTER_STICKY_EN
    output logic [WIDTH-1:0]      FALL,
    input  logic [WIDTH-1:0]      EDGE_CLR,
    output logic [WIDTH-1:0]      EDGE_STS
`else
    output logic [WIDTH-1:0]      FALL
`endif
);

    logic [WIDTH-1:0] en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign en[i] = CONFIG_DONE & (DIR[i] == GPIO_DIR_IN);

        gpio_in_filter_bit #(
            .SyncStages (SYNC_STAGES),
            .FiltCntW   (FILT_CNT_W)
        ) u_bit (
            .clk_i      (clk),
            .rst_i      (reset),
            .en_i       (en[i]),
            .filt_len_i (FILT_LEN),
            .pad_i      (SOC_IN[i]),
            .level_o    (FPGA_IN[i]),
            .rise_o     (RISE[i]),
            .fall_o     (FALL[i])
        );
    end

`ifdef GPIO_IN_FILTER_STICKY_EN
    logic [WIDTH-1:0] sts_q;

    // Sticky edge status: set beats write-1-clear, disabled bits held clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sts_q <= '0;
        end else begin
            sts_q <= en & (RISE | FALL | (sts_q & ~EDGE_CLR));
        end
    end

    assign EDGE_STS = sts_q;
`endif

endmodule
